core_dmem_wb_bridge: RTL



---
 rtl/core_dmem_wb_bridge.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/core_dmem_wb_bridge.sv
// core_dmem_wb_bridge
//   Data-side bridge between the rv32i MEM stage and a Wishbone B4 classic bus.
//   Each load or store request becomes one Wishbone cycle. The pipeline stays
//   stalled until the cycle ends. Completion is a one-cycle mem_ack_mem pulse
//   with lane-aligned, sign- or zero-extended load data.
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset
//   mem_addr_mem[31:0]        byte address from the core
//   mem_wdata_mem[31:0]       store data, LSB-justified
//   mem_op_mem[2:0]           funct3 size/sign (B, H, W, BU, HU)
//   mem_read_mem/write_mem    request strobes (never both set)
//   mem_rdata_mem[31:0]       extended load data, held between completions
//   mem_ack_mem               completion pulse (DONE state)
//   stall_pipl                pipeline freeze
//   misaligned_o, bus_err_o   completion status, valid with mem_ack_mem only
//   wb_*                      Wishbone B4 classic master signals
module core_dmem_wb_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] mem_addr_mem,
  input  logic [31:0] mem_wdata_mem,
  input  logic [2:0]  mem_op_mem,
  input  logic        mem_read_mem,
  input  logic        mem_write_mem,
  output logic [31:0] mem_rdata_mem,
  output logic        mem_ack_mem,
  output logic        stall_pipl,
  output logic        misaligned_o,
  output logic        bus_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  localparam logic [16:0] TO_LIM = 17'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic        req;
  logic        misal;
  logic        timeout;
  logic        cyc_q;
  logic        we_q;
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic [3:0]  sel_q;
  logic [15:0] cnt_q;
  logic [2:0]  op_q;
  logic [1:0]  off_q;
  logic [31:0] rdata_q;
  logic        mis_q;
  logic        err_q;

  // Halfwords need bit 0 clear, words (and unknown ops) need both low bits clear.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
    case (op)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return off[0];
      default:        return off != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_sel(input logic [2:0] op, input logic [1:0] off);
    case (op)
      3'b000, 3'b100: return 4'b0001 << off;
      3'b001, 3'b101: return 4'b0011 << off;
      default:        return 4'b1111;
    endcase
  endfunction

  // Replicating the store data puts it on every lane the sel could pick.
  function automatic logic [31:0] lane_data(input logic [2:0] op, input logic [31:0] wd);
    case (op)
      3'b000, 3'b100: return {4{wd[7:0]}};
      3'b001, 3'b101: return {2{wd[15:0]}};
      default:        return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] d, input logic [2:0] op,
                                              input logic [1:0] off);
    logic        [31:0] sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    sh = d >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (op)
      3'b000:  r = b;
      3'b001:  r = h;
      3'b100:  r = {24'd0, sh[7:0]};
      3'b101:  r = {16'd0, sh[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  assign req     = mem_read_mem | mem_write_mem;
  assign misal   = is_misaligned(mem_op_mem, mem_addr_mem[1:0]);
  // The counter value is one behind the number of BUS cycles spent so far.
  assign timeout = ({1'b0, cnt_q} + 17'd1) >= TO_LIM;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    stall_pipl = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          stall_pipl = 1'b1;
          state_d    = misal ? DONE : BUS;
        end
      end
      BUS: begin
        stall_pipl = 1'b1;
        if (wb_err_i || timeout || wb_ack_i) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      off_q   <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            op_q  <= mem_op_mem;
            off_q <= mem_addr_mem[1:0];
            mis_q <= misal;
            err_q <= 1'b0;
            cnt_q <= '0;
            if (misal) begin
              rdata_q <= '0;
            end else begin
              cyc_q <= 1'b1;
              we_q  <= mem_write_mem;
              adr_q <= {mem_addr_mem[31:2], 2'b00};
              sel_q <= lane_sel(mem_op_mem, mem_addr_mem[1:0]);
              dat_q <= lane_data(mem_op_mem, mem_wdata_mem);
            end
          end
        end
        BUS: begin
          cnt_q <= cnt_q + 16'd1;
          // Error (including timeout) takes priority over a simultaneous ack.
          if (wb_err_i || timeout) begin
            cyc_q   <= 1'b0;
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else if (wb_ack_i) begin
            cyc_q   <= 1'b0;
            rdata_q <= we_q ? 32'd0 : load_extend(wb_dat_i, op_q, off_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign wb_cyc_o      = cyc_q;
  assign wb_stb_o      = cyc_q;
  assign wb_we_o       = we_q;
  assign wb_adr_o      = adr_q;
  assign wb_dat_o      = dat_q;
  assign wb_sel_o      = sel_q;
  assign mem_rdata_mem = rdata_q;
  assign mem_ack_mem   = (state_q == DONE);
  assign misaligned_o  = (state_q == DONE) && mis_q;
  assign bus_err_o     = (state_q == DONE) && err_q;

endmodule
